// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the block-RAM FIFO controller and its output skid buffer.
package bram_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  // Pointers carry one extra bit so a full RAM can be told apart from an empty one.
  function automatic int occ_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_skid2.sv
// fifo_skid2: two-entry show-ahead skid buffer fed by the RAM read port.
module fifo_skid2
  import bram_fifo_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] load_data_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 pop_o,
  output logic [1:0]           skid_cnt_o
);

  logic [DataWidth-1:0] head_q, head_d;
  logic [DataWidth-1:0] tail_q, tail_d;
  skid_cnt_t            cnt_q, cnt_d, cnt_after_pop;

  assign out_valid_o = (cnt_q != '0);
  assign pop_o       = out_valid_o & out_ready_i;
  assign out_data_o  = head_q;
  assign skid_cnt_o  = cnt_q;

  // A pop shifts tail into head first; returning RAM data then takes the first free slot.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_after_pop = cnt_q - skid_cnt_t'(pop_o);
    if (pop_o) begin
      head_d = tail_q;
    end
    if (load_i) begin
      if (cnt_after_pop == '0) begin
        head_d = load_data_i;
      end else begin
        tail_d = load_data_i;
      end
    end
    cnt_d = cnt_after_pop + skid_cnt_t'(load_i);
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller driving both ports of an external dual-port block RAM.
// Optional registered almost_full flag is enabled with BRAM_FIFO_ALMOST_FULL_EN.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 8
`ifdef BRAM_FIFO_ALMOST_FULL_EN
  ,
  parameter int AlmostFullLevel = (2 ** AddrWidth) - 2
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic [AddrWidth+1:0] count,
  output logic                 ram_wea,
  output logic [AddrWidth-1:0] ram_addra,
  output logic [DataWidth-1:0] ram_dina,
  output logic                 ram_enb,
  output logic [AddrWidth-1:0] ram_addrb,
  input  logic [DataWidth-1:0] ram_doutb
`ifdef BRAM_FIFO_ALMOST_FULL_EN
  ,
  output logic                 almost_full
`endif
);

  localparam int              OccW    = occ_width(AddrWidth);
  localparam int              CntW    = AddrWidth + 2;
  localparam logic [OccW-1:0] FullOcc = OccW'(2 ** AddrWidth);

  logic [OccW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ;
  logic            inflight_q, inflight_d;
  logic            reset_q;
  logic            push;
  logic            pop;
  logic [1:0]      skid_cnt;
  logic [2:0]      pending;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign in_ready = !reset && !reset_q && (occ != FullOcc);
  assign push     = in_valid & in_ready;

  assign ram_wea   = push;
  assign ram_addra = wr_ptr_q[AddrWidth-1:0];
  assign ram_dina  = in_data;

  // Reads only run ahead far enough to land in a free skid slot, so the skid never overflows.
  assign pending   = {2'b00, inflight_q} + {1'b0, skid_cnt} - {2'b00, pop};
  assign ram_enb   = (occ != '0) && (pending < 3'(SKID_DEPTH));
  assign ram_addrb = rd_ptr_q[AddrWidth-1:0];

  assign count = CntW'(occ) + CntW'(inflight_q) + CntW'(skid_cnt);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + OccW'(push);
    rd_ptr_d   = rd_ptr_q + OccW'(ram_enb);
    inflight_d = ram_enb;
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_skid2 #(
    .DataWidth(DataWidth)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load_i     (inflight_q),
    .load_data_i(ram_doutb),
    .out_ready_i(out_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .pop_o      (pop),
    .skid_cnt_o (skid_cnt)
  );

`ifdef BRAM_FIFO_ALMOST_FULL_EN
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count >= CntW'(AlmostFullLevel));
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl against a queue-based reference model.
module tb_bram_fifo_ctrl;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int CAP = (2 ** AW) + 2;
`ifdef BRAM_FIFO_ALMOST_FULL_EN
  localparam int AFL = 4;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] count;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;
`ifdef BRAM_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  // Behavioural dual-port RAM, both ports on the same clock, one-cycle read latency.
  logic [DW-1:0] mem [0:(2**AW)-1];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  bram_fifo_ctrl #(
    .AddrWidth(AW),
    .DataWidth(DW)
`ifdef BRAM_FIFO_ALMOST_FULL_EN
    ,
    .AlmostFullLevel(AFL)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .ram_wea  (ram_wea),
    .ram_addra(ram_addra),
    .ram_dina (ram_dina),
    .ram_enb  (ram_enb),
    .ram_addrb(ram_addrb),
    .ram_doutb(ram_doutb)
`ifdef BRAM_FIFO_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] qData[$];
  int            qStamp[$];
  logic          rstPrev = 1'b1;
  logic          checkCap = 1'b0;
`ifdef BRAM_FIFO_ALMOST_FULL_EN
  logic          afExp = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: compare outputs with the model mid-cycle, then advance the model.
  // A word is visible three cycles after it is pushed, and the FIFO refuses input only when it
  // holds its full capacity or during/just after reset.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                               input logic rst);
    logic expReady;
    logic expValid;
    logic pushM;
    logic popM;
    int   depth;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    reset     = rst;
    #2;
    depth    = qData.size();
    expReady = !rst && !rstPrev && (depth < CAP);
    expValid = 1'b0;
    if (depth > 0) expValid = (qStamp[0] <= cyc - 3);
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(expValid));
    if (expValid) checkOutput("out_data", 32'(out_data), 32'(qData[0]));
    checkOutput("count", 32'(count), 32'(depth));
    checkOutput("collision", 32'(ram_wea & ram_enb & (ram_addra == ram_addrb)), 32'(0));
    if (checkCap) checkOutput("count_le_cap", 32'(count <= 4'(CAP)), 32'(1));
`ifdef BRAM_FIFO_ALMOST_FULL_EN
    checkOutput("almost_full", 32'(almost_full), 32'(afExp));
`endif
    pushM = iv && expReady;
    popM  = expValid && ordy;
    @(posedge clk);
    #1;
    if (rst) begin
      qData.delete();
      qStamp.delete();
    end else begin
      if (popM) begin
        void'(qData.pop_front());
        void'(qStamp.pop_front());
      end
      if (pushM) begin
        qData.push_back(d);
        qStamp.push_back(cyc);
      end
    end
`ifdef BRAM_FIFO_ALMOST_FULL_EN
    afExp = !rst && (depth >= AFL);
`endif
    rstPrev = rst;
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ordy, 1'b0);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle(1, 1'b0);

    // Single word latency
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(4, 1'b0);
    checkOutput("a5_head", 32'(out_data), 32'h A5);
    idle(3, 1'b1);

    // Fill to capacity, then drain in order
    resetCycle();
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("full_count", 32'(count), 32'(CAP));
    idle(10, 1'b1);
    checkOutput("drained_count", 32'(count), 32'(0));

    // Streaming with many pointer wraps
    resetCycle();
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Random traffic
    checkCap = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    checkCap = 1'b0;
    idle(10, 1'b1);

    // Reset while a read is in flight must discard everything
    resetCycle();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("post_reset_count", 32'(count), 32'(0));
    checkOutput("post_reset_valid", 32'(out_valid), 32'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("no_stale", 32'(out_data), 32'h5A);
    idle(3, 1'b1);

`ifdef BRAM_FIFO_ALMOST_FULL_EN
    // Almost-full threshold crossing in both directions
    resetCycle();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("af_set", 32'(almost_full), 32'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(2, 1'b0);
    checkOutput("af_clear", 32'(almost_full), 32'(0));
    idle(6, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that owns both ports of the team's behavioural dual-port block RAM, with the same clock driving both ports.
- Port A is write-only (enqueue side). Port B is read-only (dequeue side).
- Hides the RAM's 1-cycle read latency behind a 2-entry show-ahead output skid buffer, giving a full-throughput valid/ready stream in and out.
- Sits between a producer stream and the RAM instance; the RAM is external to this block.

Parameters:
- AddrWidth, 10, RAM address width; RAM depth = 2^AddrWidth words.
- DataWidth, 8, word width.

Ports:
- clk  in  1  single clock; the RAM's clka and clkb are tied to it.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  DataWidth  producer word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes a word.
- out_data  out  DataWidth  head word, from the skid head entry.
- count  out  AddrWidth+2  words held: RAM occupancy + reads in flight + skid entries.
- ram_wea  out  1  port A write enable; ram_ena is tied to the same signal.
- ram_addra  out  AddrWidth  write address.
- ram_dina  out  DataWidth  write data.
- ram_enb  out  1  port B read enable; ram_web is tied to 0.
- ram_addrb  out  AddrWidth  read address.
- ram_doutb  in  DataWidth  RAM read data; valid the cycle after ram_enb.

Behaviour:
- Pointers
  - wr_ptr and rd_ptr are AddrWidth+1 bits.
  - occ = wr_ptr - rd_ptr, range 0..2^AddrWidth.
- Enqueue
  - in_ready = !reset_q && occ != 2^AddrWidth.
  - Push = in_valid & in_ready.
  - On push: ram_wea=1, ram_addra=wr_ptr[AddrWidth-1:0], ram_dina=in_data, all combinational; wr_ptr increments.
- Read issue
  - ram_enb = (occ != 0) && (inflight + skid_cnt - pop < 2).
  - ram_addrb = rd_ptr low bits; rd_ptr increments on issue.
  - inflight is a 1-bit register: set on issue, cleared the next cycle.
- Skid
  - 2 entries, head and tail.
  - When inflight=1, ram_doutb is loaded into the first free slot after any same-cycle pop.
  - out_valid = skid_cnt != 0.
  - pop = out_valid & out_ready.
  - A pop shifts tail into head.
- Latency
  - Empty FIFO, push in cycle 0: read issued cycle 1, captured cycle 2, out_valid=1 in cycle 3.
  - Steady-state throughput is 1 word/clk in and out simultaneously.
- Capacity
  - Total capacity is 2^AddrWidth + 2.
  - in_ready depends only on occ.
- Collision rule
  - A port A write and a port B read to the same address in the same cycle must never occur.
  - This is guaranteed because reads use the registered occ, and writes are blocked when occ is full.
  - The RAM's same-address collision semantics are therefore never exercised.
- Simultaneous push and pop at any fill level:
  - count stays unchanged.
  - Ordering is strict FIFO.
  - Full/empty are unaffected across pointer wrap; the MSB distinguishes full from empty.
- Ignored inputs
  - in_valid while !in_ready: no state change; in_data is ignored.
  - out_ready while !out_valid: ignored.
- Reset
  - When reset=1 at a clock edge, the following take effect next cycle: wr_ptr=rd_ptr=0, inflight=0, skid_cnt=0, out_valid=0, count=0, ram_wea=0, ram_enb=0.
  - in_ready=0 for the reset cycle and the cycle after it (reset_q); it is 1 thereafter.
  - Mid-operation reset discards all words, including in-flight read data. RAM contents are not cleared.

Optional Feature:
- Macro: BRAM_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds parameter AlmostFullLevel, default 2^AddrWidth - 2.
  - Adds port almost_full (out, 1): registered, asserted the cycle after count >= AlmostFullLevel becomes true, deasserted likewise.
  - Reset value is 0.
- Undefined: neither the parameter nor the port exists; no extra logic.

Decomposition:
- Shared package bram_fifo_pkg holds:
  - function for occupancy width: AddrWidth+1;
  - constant SKID_DEPTH=2;
  - typedef for skid count (2 bits).
- One sub-module, fifo_skid2: 2-entry valid/ready skid buffer with load-from-RAM input, pop, skid_cnt output.
- The top-level block keeps the pointers and the issue logic.

Test Plan (AddrWidth=2, DataWidth=8, bench instantiates the dual-port RAM with both clocks tied):
- Reset, then push 0xA5 in cycle 0 with out_ready=0 -> out_valid rises in cycle 3 with out_data=0xA5; count=1 from cycle 1 onward.
- out_ready=0, push 0x01..0x07 back-to-back -> accepted 0x01..0x06, in_ready=0 from cycle after 6th push, count=6; then pop all -> 0x01..0x06 in order, count=0, out_valid=0.
- Continuous push and pop of 0x00..0x3F (pointer wraps 8+ times) -> output identical sequence at 1 word/clk after initial 3-cycle latency; assertion never fires (ram_wea & ram_enb & ram_addra==ram_addrb).
- Random in_valid/out_ready at 50% for 2000 cycles -> scoreboard match, count equals scoreboard depth every cycle, count never exceeds 6.
- Fill with 4 words, assert reset for 1 cycle while a read is in flight -> next cycle count=0, out_valid=0; push 0x5A -> first output is 0x5A (no stale data).
- With BRAM_FIFO_ALMOST_FULL_EN and AlmostFullLevel=4: push 4 words with out_ready=0 -> almost_full=1 the cycle after count reaches 4; pop one -> almost_full=0 one cycle after count=3.
